// File: rtl/mult_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_mem_pkg                                                 |
// | Description : Shared definitions for the memory-fed sequential multiplier. |
// |               Default widths, FSM state encoding and counter-width helper. |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mult_mem_pkg;

  // Default geometry of the multiplier and its operand store
  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DEPTH  = 8;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_MULT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Width of a counter that must hold the values 0..data_w
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage : mult_mem_pkg
`default_nettype wire

// File: rtl/mult_mem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_mem_ram                                                 |
// | Description : DEPTH x DATA_W operand RAM, one write port and two           |
// |               synchronous read ports with read-before-write behaviour.     |
// |               Out-of-range writes are dropped, out-of-range reads give 0.  |
// |               Storage is not reset.                                        |
// | Ports       : clk                        - clock, rising edge              |
// |               wr_en/wr_addr/wr_data      - write port                      |
// |               rd_addr1/rd_addr2          - read addresses                  |
// |               rd_data1/rd_data2          - registered read data            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mult_mem_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  // One extra bit so DEPTH == 2**ADDR_W is representable
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Non-blocking update gives read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < C_DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data1 <= ({1'b0, rd_addr1} < C_DEPTH) ? mem[rd_addr1] : '0;
    rd_data2 <= ({1'b0, rd_addr2} < C_DEPTH) ? mem[rd_addr2] : '0;
  end

endmodule : mult_mem_ram
`default_nettype wire

// File: rtl/mult_mem_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_mem_seq                                                 |
// | Description : Writable operand RAM feeding a shift-add multiplier.         |
// |               start (in IDLE) reads two operands; the product appears on   |
// |               d_out with a one-cycle done pulse DATA_W+2 cycles later.     |
// | Ports       : clk, rst            - clock, synchronous active-high reset   |
// |               wr_en/addr/data     - operand memory write port              |
// |               start/addr1/addr2   - multiply request and operand addresses |
// |               sgn                 - signed request (MULT_SIGNED_EN only)   |
// |               busy/done/d_out     - status and 2*DATA_W product            |
// | Options     : `define MULT_SIGNED_EN adds two's complement support (sgn).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mult_mem_seq
  import mult_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                start,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [ADDR_W-1:0]   addr2,
`ifdef MULT_SIGNED_EN
  input  logic                sgn,
`endif
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] d_out
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic [DATA_W-1:0] op_a, op_b;
  logic [PW-1:0]     acc, acc_next, result;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mag1, mag2;

  // The read ports sample the live addresses every cycle, so the data seen
  // in FETCH is the memory content at the edge where start was accepted.
  mult_mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (addr1),
    .rd_addr2 (addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

`ifdef MULT_SIGNED_EN
  logic sgn_q;
  logic neg_q;

  // Magnitude of a two's complement operand; the most negative value maps
  // to 2**(DATA_W-1), which still fits as an unsigned DATA_W-bit number.
  assign mag1   = (sgn_q && rd_data1[DATA_W-1]) ? (~rd_data1 + 1'b1) : rd_data1;
  assign mag2   = (sgn_q && rd_data2[DATA_W-1]) ? (~rd_data2 + 1'b1) : rd_data2;
  assign result = neg_q ? (~acc_next + 1'b1) : acc_next;
`else
  assign mag1   = rd_data1;
  assign mag2   = rd_data2;
  assign result = acc_next;
`endif

  always_comb begin
    acc_next = acc;
    if (op_b[0]) begin
      acc_next = acc + ({{DATA_W{1'b0}}, op_a} << count);
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
      d_out <= '0;
      acc   <= '0;
      count <= '0;
      op_a  <= '0;
      op_b  <= '0;
`ifdef MULT_SIGNED_EN
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
`ifdef MULT_SIGNED_EN
            sgn_q <= sgn;
`endif
          end
        end
        ST_FETCH: begin
          op_a  <= mag1;
          op_b  <= mag2;
          acc   <= '0;
          count <= '0;
`ifdef MULT_SIGNED_EN
          neg_q <= sgn_q & (rd_data1[DATA_W-1] ^ rd_data2[DATA_W-1]);
`endif
          state <= ST_MULT;
        end
        ST_MULT: begin
          acc   <= acc_next;
          op_b  <= op_b >> 1;
          count <= count + 1'b1;
          // Publish the product on entry to DONE so d_out and done are
          // both visible during the DONE cycle itself.
          if (count == C_LAST) begin
            state <= ST_DONE;
            d_out <= result;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : mult_mem_seq
`default_nettype wire

// File: tb/tb_mult_mem_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mult_mem_seq                                              |
// | Description : Scoreboard bench for mult_mem_seq (DATA_W=4, ADDR_W=3,       |
// |               DEPTH=8). Stimulus pushes expected products with their due   |
// |               cycle; a monitor pops and checks on every done pulse.        |
// | Options     : MULT_SIGNED_EN enables the sgn port and signed cases.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mult_mem_seq;

  localparam int LAT = 6;   // DATA_W + 2

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       start = 1'b0;
  logic [2:0] addr1 = '0;
  logic [2:0] addr2 = '0;
  logic       sgn = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] d_out;

  mult_mem_seq #(
    .DATA_W (4),
    .ADDR_W (3),
    .DEPTH  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .addr1   (addr1),
    .addr2   (addr2),
`ifdef MULT_SIGNED_EN
    .sgn     (sgn),
`endif
    .busy    (busy),
    .done    (done),
    .d_out   (d_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] prod;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mem_m[8];
  int         next_free = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         busy_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b,
                                          input bit s);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    if (s && a[3]) ia -= 16;
    if (s && b[3]) ib -= 16;
    return 8'(ia * ib);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus. An operation occupies the unit for LAT cycles
  // after acceptance plus the return to IDLE, so a start is taken only
  // when the bench's own occupancy record says the unit is free. The
  // product uses memory as it was before this cycle's write.
  task automatic drive(input bit we, input logic [2:0] wa, input logic [3:0] wd,
                       input bit st, input logic [2:0] a1, input logic [2:0] a2,
                       input bit s);
    bit s_eff;
    s_eff   = SIGNED_BUILD & s;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    start   = st;
    addr1   = a1;
    addr2   = a2;
    sgn     = s_eff;
    if (st && cyc >= next_free) begin
      exp_q.push_back('{prod: ref_prod(mem_m[a1], mem_m[a2], s_eff), due: cyc + LAT});
      next_free = cyc + LAT + 1;
    end
    if (we) mem_m[wa] = wd;
    step();
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic wr(input logic [2:0] wa, input logic [3:0] wd);
    drive(1'b1, wa, wd, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic go(input logic [2:0] a1, input logic [2:0] a2, input bit s);
    drive(1'b0, 3'd0, 4'd0, 1'b1, a1, a2, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_free();
    while (cyc < next_free) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    next_free = cyc;
  endtask

  // Monitor: every done pulse must match the oldest outstanding request,
  // arrive exactly on its due cycle and follow exactly LAT busy cycles.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", 64'(d_out), 64'(e.prod));
          chk("latency", cyc, e.due);
          chk("busy_cycles", busy_cnt, LAT);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    idle(2);
    rst = 1'b0;
    next_free = cyc;
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_dout", 64'(d_out), 0);

    for (int i = 0; i < 8; i++) wr(3'(i), 4'd0);

    // Basic products
    wr(3'd1, 4'd12);
    wr(3'd2, 4'd6);
    go(3'd1, 3'd2, 1'b0);                // 72
    wait_free();
    wr(3'd3, 4'd7);
    wr(3'd4, 4'd8);
    go(3'd3, 3'd4, 1'b0);                // 56
    wait_free();
    wr(3'd6, 4'd15);
    wr(3'd7, 4'd15);
    go(3'd6, 3'd7, 1'b0);                // 225
    wait_free();
    wr(3'd0, 4'd0);
    wr(3'd5, 4'd1);
    go(3'd0, 3'd5, 1'b0);                // 0, full latency
    wait_free();

    // Start while busy is dropped; a write during MULT does not disturb
    go(3'd1, 3'd2, 1'b0);                // 72
    idle(1);
    go(3'd1, 3'd2, 1'b0);                // ignored
    wr(3'd2, 4'd3);
    wait_free();
    go(3'd1, 3'd2, 1'b0);                // 36, back-to-back with the last DONE
    wait_free();

    // Reset in the middle of an operation
    go(3'd1, 3'd2, 1'b0);
    idle(2);
    do_reset();
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_done", 64'(done), 0);
    chk("midrst_dout", 64'(d_out), 0);
    idle(8);
    go(3'd6, 3'd1, 1'b0);                // 180
    wait_free();

    // Read-before-write on the same cycle as start
    wr(3'd5, 4'd9);
    drive(1'b1, 3'd5, 4'd2, 1'b1, 3'd5, 3'd7, 1'b0);   // uses 9, not 2
    wait_free();
    go(3'd5, 3'd7, 1'b0);                // now 2*15
    wait_free();

    if (SIGNED_BUILD) begin
      wr(3'd1, 4'hC);
      wr(3'd2, 4'd3);
      go(3'd1, 3'd2, 1'b1);              // -12 -> F4
      wait_free();
      go(3'd1, 3'd2, 1'b0);              // 36
      wait_free();
    end

    // Randomised traffic: overlapping writes, starts while busy, back-to-back
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) == 0), 3'($urandom), 4'($urandom),
            ($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom),
            1'($urandom));
    end
    wait_free();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mult_mem_seq
`default_nettype wire
